div_sequencer: RTL and testbench

DIV_SEQUENCER -- requirements
Module: div_sequencer

---
 rtl/div_sequencer.sv | 94 +++++++++
 tb/tb_div_sequencer.sv | 292 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/div_sequencer.sv
// div_sequencer: sign-handling sequencer that wraps an unsigned divider core
module div_sequencer #(
  parameter int DATA_WIDTH = 32,
  parameter int TAG_WIDTH  = 5
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  req_valid_i,
  output logic                  req_ready_o,
  input  logic [1:0]            op_i,
  input  logic [DATA_WIDTH-1:0] rs1_i,
  input  logic [DATA_WIDTH-1:0] rs2_i,
  input  logic [TAG_WIDTH-1:0]  tag_i,
  input  logic                  flush_i,
  output logic                  core_start_o,
  output logic [DATA_WIDTH-1:0] core_dividend_o,
  output logic [DATA_WIDTH-1:0] core_divisor_o,
  input  logic                  core_done_i,
  input  logic [DATA_WIDTH-1:0] core_quotient_i,
  input  logic [DATA_WIDTH-1:0] core_remainder_i,
  output logic                  rsp_valid_o,
  input  logic                  rsp_ready_i,
  output logic [DATA_WIDTH-1:0] rsp_data_o,
  output logic [TAG_WIDTH-1:0]  rsp_tag_o,
  output logic                  rsp_dbz_o
);
  typedef enum logic [2:0] {IDLE, ISSUE, WAIT, FIXUP, RESP, DRAIN} state_t;
  localparam logic [DATA_WIDTH-1:0] MIN_NEG = {1'b1, {(DATA_WIDTH-1){1'b0}}};
  localparam logic [DATA_WIDTH-1:0] ONES = {DATA_WIDTH{1'b1}};
  state_t state, state_nxt;
  logic accept, is_signed, a_neg, b_neg, dbz, ovf, special;
  logic [DATA_WIDTH-1:0] special_data, raw_q;
  logic is_rem_q, neg_q_q, neg_r_q;
  assign accept = req_valid_i & req_ready_o;
  // request decode: operand signs and the two cases that bypass the core
  always_comb begin
    is_signed = ~op_i[0];
    a_neg = is_signed & rs1_i[DATA_WIDTH-1];
    b_neg = is_signed & rs2_i[DATA_WIDTH-1];
    dbz = rs2_i == '0;
    ovf = is_signed & (rs1_i == MIN_NEG) & (rs2_i == ONES);
    special = dbz | ovf;
    special_data = dbz ? (op_i[1] ? rs1_i : ONES) : (op_i[1] ? '0 : rs1_i);
  end
  // state register
  always_ff @(posedge clk_i)
    state <= rst_i ? IDLE : state_nxt;
  // next-state logic, flush aborts everything except the core itself
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    state_nxt = accept ? (special ? RESP : ISSUE) : IDLE;
      ISSUE:   state_nxt = flush_i ? IDLE : WAIT;
      WAIT:    state_nxt = core_done_i ? (flush_i ? IDLE : FIXUP) : (flush_i ? DRAIN : WAIT);
      FIXUP:   state_nxt = flush_i ? IDLE : RESP;
      RESP:    state_nxt = (flush_i | rsp_ready_i) ? IDLE : RESP;
      DRAIN:   state_nxt = core_done_i ? IDLE : DRAIN;
      default: state_nxt = IDLE;
    endcase
  end
  // handshake outputs decoded from state
  always_comb begin
    req_ready_o = state == IDLE;
    core_start_o = state == ISSUE;
    rsp_valid_o = state == RESP;
  end
  // operand capture, core result capture and sign fixup
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      core_dividend_o <= '0;
      core_divisor_o <= '0;
      is_rem_q <= 1'b0;
      neg_q_q <= 1'b0;
      neg_r_q <= 1'b0;
      raw_q <= '0;
      rsp_data_o <= '0;
      rsp_tag_o <= '0;
      rsp_dbz_o <= 1'b0;
    end else begin
      if (accept) begin
        core_dividend_o <= a_neg ? -rs1_i : rs1_i;
        core_divisor_o <= b_neg ? -rs2_i : rs2_i;
        is_rem_q <= op_i[1];
        neg_q_q <= a_neg ^ b_neg;
        neg_r_q <= a_neg;
        rsp_tag_o <= tag_i;
        rsp_dbz_o <= dbz;
        if (special) rsp_data_o <= special_data;
      end
      if (state == WAIT && core_done_i) raw_q <= is_rem_q ? core_remainder_i : core_quotient_i;
      if (state == FIXUP && !flush_i) rsp_data_o <= (is_rem_q ? neg_r_q : neg_q_q) ? -raw_q : raw_q;
    end
  end
endmodule

// File: tb/tb_div_sequencer.sv
// tb_div_sequencer: directed checks of div_sequencer against a signed-arithmetic model
module tb_div_sequencer;
  localparam int W = 32;
  localparam int T = 5;
  logic clk_i = 1'b0;
  logic rst_i, req_valid_i, req_ready_o, flush_i, core_start_o, core_done_i;
  logic rsp_valid_o, rsp_ready_i, rsp_dbz_o;
  logic [1:0] op_i;
  logic [W-1:0] rs1_i, rs2_i, core_dividend_o, core_divisor_o, core_quotient_i, core_remainder_i, rsp_data_o;
  logic [T-1:0] tag_i, rsp_tag_o;
  int total = 0, bad = 0, starts = 0, core_lat = 3;
  logic exp_pending = 1'b0, exp_dbz = 1'b0, exp_spec = 1'b0, prev_start = 1'b0;
  logic [W-1:0] exp_data = '0, exp_ma = '0, exp_mb = '0;
  logic [T-1:0] exp_tag = '0;

  div_sequencer #(.DATA_WIDTH(W), .TAG_WIDTH(T)) dut (
    .clk_i(clk_i), .rst_i(rst_i), .req_valid_i(req_valid_i), .req_ready_o(req_ready_o),
    .op_i(op_i), .rs1_i(rs1_i), .rs2_i(rs2_i), .tag_i(tag_i), .flush_i(flush_i),
    .core_start_o(core_start_o), .core_dividend_o(core_dividend_o), .core_divisor_o(core_divisor_o),
    .core_done_i(core_done_i), .core_quotient_i(core_quotient_i), .core_remainder_i(core_remainder_i),
    .rsp_valid_o(rsp_valid_o), .rsp_ready_i(rsp_ready_i), .rsp_data_o(rsp_data_o),
    .rsp_tag_o(rsp_tag_o), .rsp_dbz_o(rsp_dbz_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  // RISC-V style division semantics expressed with plain signed/unsigned arithmetic
  function automatic void model(input logic [1:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                                output logic [W-1:0] res, output logic dz, output logic sp,
                                output logic [W-1:0] ma, output logic [W-1:0] mb);
    logic sg, rem;
    sg = !op[0];
    rem = op[1];
    dz = (b == 0);
    sp = 1'b1;
    if (dz) res = rem ? a : 32'hFFFF_FFFF;
    else if (sg && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) res = rem ? 32'h0 : a;
    else begin
      sp = 1'b0;
      if (sg) res = rem ? $signed(a) % $signed(b) : $signed(a) / $signed(b);
      else res = rem ? a % b : a / b;
    end
    ma = (sg && $signed(a) < 0) ? 32'h0 - a : a;
    mb = (sg && $signed(b) < 0) ? 32'h0 - b : b;
  endfunction

  // unsigned divider core stand-in with programmable latency
  initial begin
    logic [W-1:0] a, b;
    core_done_i = 1'b0;
    core_quotient_i = '0;
    core_remainder_i = '0;
    forever begin
      @(negedge clk_i);
      if (core_start_o) begin
        starts++;
        a = core_dividend_o;
        b = core_divisor_o;
        chk("core_dividend", a, exp_ma);
        chk("core_divisor", b, exp_mb);
        repeat (core_lat) @(posedge clk_i);
        #1;
        core_done_i = 1'b1;
        core_quotient_i = a / b;
        core_remainder_i = a % b;
        @(posedge clk_i);
        #1;
        core_done_i = 1'b0;
        core_quotient_i = $urandom;
        core_remainder_i = $urandom;
      end
    end
  end

  // response compare: every valid cycle must match the pending expectation
  always @(negedge clk_i) begin
    if (core_start_o) chk("start_single_cycle", {31'b0, prev_start}, 32'd0);
    prev_start <= core_start_o;
    if (rsp_valid_o) begin
      chk("rsp_expected", {31'b0, exp_pending}, 32'd1);
      chk("rsp_data", rsp_data_o, exp_data);
      chk("rsp_tag", {27'b0, rsp_tag_o}, {27'b0, exp_tag});
      chk("rsp_dbz", {31'b0, rsp_dbz_o}, {31'b0, exp_dbz});
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  task automatic accept_only(input logic [1:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                             input logic [T-1:0] tag, input bit fl);
    model(op, a, b, exp_data, exp_dbz, exp_spec, exp_ma, exp_mb);
    exp_tag = tag;
    op_i = op; rs1_i = a; rs2_i = b; tag_i = tag; req_valid_i = 1'b1; flush_i = fl;
    @(negedge clk_i);
    chk("req_ready_idle", {31'b0, req_ready_o}, 32'd1);
    @(posedge clk_i);
    #1;
    req_valid_i = 1'b0; flush_i = 1'b0;
    rs1_i = $urandom; rs2_i = $urandom; op_i = 2'($urandom); tag_i = 5'($urandom);
  endtask

  task automatic do_op(input logic [1:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                       input logic [T-1:0] tag, input int hold, input bit fl, input logic [W-1:0] lit);
    int s0, n;
    s0 = starts;
    accept_only(op, a, b, tag, fl);
    exp_pending = 1'b1;
    chk("model_pin", exp_data, lit);
    n = 0;
    do begin
      @(negedge clk_i);
      n++;
    end while (!rsp_valid_o && n < 100);
    chk("latency", n, exp_spec ? 1 : 3 + core_lat);
    for (int i = 0; i < hold; i++) begin
      chk("hold_ready_low", {31'b0, req_ready_o}, 32'd0);
      chk("hold_valid", {31'b0, rsp_valid_o}, 32'd1);
      @(negedge clk_i);
    end
    chk("handshake_ready_low", {31'b0, req_ready_o}, 32'd0);
    rsp_ready_i = 1'b1;
    @(posedge clk_i);
    #1;
    rsp_ready_i = 1'b0;
    exp_pending = 1'b0;
    @(negedge clk_i);
    chk("after_ready", {31'b0, req_ready_o}, 32'd1);
    chk("after_valid", {31'b0, rsp_valid_o}, 32'd0);
    chk("core_starts", starts - s0, exp_spec ? 0 : 1);
    @(posedge clk_i);
    #1;
  endtask

  initial begin
    rst_i = 1'b1; req_valid_i = 1'b0; flush_i = 1'b0; rsp_ready_i = 1'b0;
    op_i = '0; rs1_i = '0; rs2_i = '0; tag_i = '0;
    repeat (2) @(posedge clk_i);
    @(negedge clk_i);
    chk("rst_ready", {31'b0, req_ready_o}, 32'd1);
    chk("rst_start", {31'b0, core_start_o}, 32'd0);
    chk("rst_valid", {31'b0, rsp_valid_o}, 32'd0);
    chk("rst_dbz", {31'b0, rsp_dbz_o}, 32'd0);
    chk("rst_data", rsp_data_o, 32'd0);
    chk("rst_tag", {27'b0, rsp_tag_o}, 32'd0);
    @(posedge clk_i);
    #1;
    rst_i = 1'b0;

    core_lat = 3;
    do_op(2'b00, 32'hFFFF_FFF9, 32'd2, 5'd3, 0, 1'b0, 32'hFFFF_FFFD);
    do_op(2'b10, 32'hFFFF_FFF9, 32'd2, 5'd4, 0, 1'b0, 32'hFFFF_FFFF);
    do_op(2'b01, 32'd100, 32'd0, 5'd5, 0, 1'b0, 32'hFFFF_FFFF);
    do_op(2'b11, 32'd100, 32'd0, 5'd6, 0, 1'b0, 32'd100);
    do_op(2'b00, 32'd100, 32'd0, 5'd7, 0, 1'b0, 32'hFFFF_FFFF);
    do_op(2'b00, 32'h8000_0000, 32'hFFFF_FFFF, 5'd8, 0, 1'b0, 32'h8000_0000);
    do_op(2'b10, 32'h8000_0000, 32'hFFFF_FFFF, 5'd9, 0, 1'b0, 32'h0);
    do_op(2'b01, 32'd100, 32'd7, 5'd10, 0, 1'b0, 32'd14);
    do_op(2'b11, 32'd100, 32'd7, 5'd11, 0, 1'b0, 32'd2);
    do_op(2'b00, 32'd100, 32'hFFFF_FFF9, 5'd12, 0, 1'b0, 32'hFFFF_FFF2);
    do_op(2'b10, 32'd100, 32'hFFFF_FFF9, 5'd13, 0, 1'b0, 32'd2);
    do_op(2'b00, 32'hFFFF_FF9C, 32'hFFFF_FFF9, 5'd14, 0, 1'b0, 32'd14);
    do_op(2'b10, 32'hFFFF_FF9C, 32'hFFFF_FFF9, 5'd15, 0, 1'b0, 32'hFFFF_FFFE);
    do_op(2'b00, 32'h8000_0000, 32'd2, 5'd16, 0, 1'b0, 32'hC000_0000);
    do_op(2'b01, 32'h8000_0000, 32'hFFFF_FFFF, 5'd17, 0, 1'b0, 32'h0);
    do_op(2'b11, 32'h8000_0000, 32'hFFFF_FFFF, 5'd18, 0, 1'b0, 32'h8000_0000);
    do_op(2'b01, 32'd1000, 32'd10, 5'd31, 10, 1'b0, 32'd100);
    do_op(2'b11, 32'd17, 32'd5, 5'd19, 0, 1'b1, 32'd2);
    core_lat = 1;
    do_op(2'b00, 32'd9, 32'hFFFF_FFFD, 5'd20, 2, 1'b0, 32'hFFFF_FFFD);

    core_lat = 3;
    accept_only(2'b01, 32'd40, 32'd4, 5'd1, 1'b0);
    flush_i = 1'b1;
    @(posedge clk_i);
    #1;
    flush_i = 1'b0;
    @(negedge clk_i);
    chk("flush_issue_ready", {31'b0, req_ready_o}, 32'd1);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk_i);
      chk("flush_issue_no_rsp", {31'b0, rsp_valid_o}, 32'd0);
    end
    @(posedge clk_i);
    #1;

    core_lat = 6;
    accept_only(2'b01, 32'd50, 32'd5, 5'd2, 1'b0);
    @(posedge clk_i);
    #1;
    flush_i = 1'b1;
    @(posedge clk_i);
    #1;
    flush_i = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk_i);
      chk("drain_ready_low", {31'b0, req_ready_o}, 32'd0);
      chk("drain_no_rsp", {31'b0, rsp_valid_o}, 32'd0);
    end
    @(negedge clk_i);
    chk("drain_exit_ready", {31'b0, req_ready_o}, 32'd1);
    @(posedge clk_i);
    #1;

    core_lat = 2;
    accept_only(2'b00, 32'd60, 32'd6, 5'd3, 1'b0);
    repeat (2) begin
      @(posedge clk_i);
      #1;
    end
    flush_i = 1'b1;
    @(posedge clk_i);
    #1;
    flush_i = 1'b0;
    @(negedge clk_i);
    chk("flush_done_ready", {31'b0, req_ready_o}, 32'd1);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk_i);
      chk("flush_done_no_rsp", {31'b0, rsp_valid_o}, 32'd0);
    end
    @(posedge clk_i);
    #1;

    core_lat = 1;
    accept_only(2'b10, 32'd61, 32'd6, 5'd4, 1'b0);
    repeat (2) begin
      @(posedge clk_i);
      #1;
    end
    flush_i = 1'b1;
    @(posedge clk_i);
    #1;
    flush_i = 1'b0;
    @(negedge clk_i);
    chk("flush_fixup_ready", {31'b0, req_ready_o}, 32'd1);
    chk("flush_fixup_no_rsp", {31'b0, rsp_valid_o}, 32'd0);
    @(posedge clk_i);
    #1;

    accept_only(2'b01, 32'd5, 32'd0, 5'd9, 1'b0);
    exp_pending = 1'b1;
    @(negedge clk_i);
    chk("flush_resp_valid", {31'b0, rsp_valid_o}, 32'd1);
    flush_i = 1'b1;
    @(posedge clk_i);
    #1;
    flush_i = 1'b0;
    exp_pending = 1'b0;
    @(negedge clk_i);
    chk("flush_resp_dropped", {31'b0, rsp_valid_o}, 32'd0);
    chk("flush_resp_ready", {31'b0, req_ready_o}, 32'd1);
    @(posedge clk_i);
    #1;

    core_lat = 5;
    accept_only(2'b00, 32'd77, 32'd7, 5'd12, 1'b0);
    @(posedge clk_i);
    #1;
    rst_i = 1'b1;
    @(posedge clk_i);
    #1;
    rst_i = 1'b0;
    @(negedge clk_i);
    chk("rst_wait_ready", {31'b0, req_ready_o}, 32'd1);
    chk("rst_wait_valid", {31'b0, rsp_valid_o}, 32'd0);
    chk("rst_wait_data", rsp_data_o, 32'd0);
    chk("rst_wait_tag", {27'b0, rsp_tag_o}, 32'd0);
    for (int i = 0; i < 6; i++) begin
      @(negedge clk_i);
      chk("rst_wait_no_rsp", {31'b0, rsp_valid_o}, 32'd0);
    end
    @(posedge clk_i);
    #1;

    core_lat = 2;
    do_op(2'b00, 32'd77, 32'd7, 5'd21, 0, 1'b0, 32'd11);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
